// File: rtl/vga_pkg.sv
// Shared constants and fetch FSM encoding for the VGA tile-RAM
// fetch path.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int GRID     = 16;
    localparam int ADDR_W   = 8;
    localparam int RGB_W    = 24;

    // Cycles spent discarding a possibly in-flight response after an abort.
    localparam int DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/ram_read_port.sv
// Single-outstanding RAM read port: request/address in,
// done/data/timeout out, with abort-and-drain.
module ram_read_port
    import vga_pkg::*;
#(
    parameter int TIMEOUT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              abort,
    input  logic [RGB_W-1:0]  ram_rgb,
    input  logic              ram_valid,
    output logic              ready,
    output logic              ram_read,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              done,
    output logic [RGB_W-1:0]  data,
    output logic              timeout
);

    fetch_state_t state, state_nxt;
    logic [3:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0] addr_q;

    assign ram_addr = addr_q;
    assign data     = ram_rgb;

    // State, wait/drain counter and latched address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req && !abort)
                addr_q <= addr;
        end
    end

    // Next state; an abort beats everything, a response beats timeout.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        timeout   = 1'b0;
        ready     = (state == IDLE);
        ram_read  = (state == REQ);
        if (abort) begin
            if (state == IDLE) begin
                state_nxt = IDLE;
            end else begin
                state_nxt = DRAIN;
                cnt_nxt   = '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req)
                        state_nxt = REQ;
                end
                REQ: begin
                    state_nxt = WAIT;
                    cnt_nxt   = '0;
                end
                WAIT: begin
                    if (ram_valid) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else if (cnt == 4'(TIMEOUT - 1)) begin
                        timeout   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
                DRAIN: begin
                    if (cnt == 4'(DRAIN_CYCLES - 1))
                        state_nxt = IDLE;
                    else
                        cnt_nxt = cnt + 4'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vga_ram_fetch.sv
// Maps the active raster onto a 16x16 cell grid, fetches one
// RAM colour per cell into a cur/nxt buffer, drives pixel RGB.
module vga_ram_fetch
    import vga_pkg::*;
#(
    parameter int             CELL_W    = 40,
    parameter int             CELL_H    = 30,
    parameter int             TIMEOUT   = 7,
    parameter logic [RGB_W-1:0] ERR_COLOR = 24'hFF00FF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_line_start,
    input  logic              i_active,
    input  logic [RGB_W-1:0]  i_ram_rgb,
    input  logic              i_ram_valid,
    output logic              o_ram_read,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [RGB_W-1:0]  o_rgb,
    output logic              o_de,
    output logic              o_err
);

    localparam int PX_W = $clog2(CELL_W);
    localparam int LN_W = $clog2(CELL_H);
    localparam logic [3:0] LAST_FETCH_COL = 4'(GRID - 3);

    logic [PX_W-1:0] px;
    logic [3:0]      col;
    logic [LN_W-1:0] lic;
    logic [3:0]      row;
    logic            first_line;
    logic [RGB_W-1:0] cur, nxt;

    // Queued request, in-flight target (0=cur, 1=nxt), col1 chain flag.
    logic       pend, pend_tgt, tgt_q, chain;
    logic [3:0] pend_col;

    logic wrap, chain_fire, wrap_fire, new_req;
    logic req, accept, ready, done, tmo;
    logic new_tgt, req_tgt;
    logic [3:0] new_col, req_col;
    logic [ADDR_W-1:0] req_addr;
    logic [RGB_W-1:0]  port_data, fill;

    ram_read_port #(.TIMEOUT(TIMEOUT)) u_port (
        .clk       (i_clk),
        .rst       (i_rst),
        .req       (req),
        .addr      (req_addr),
        .abort     (i_line_start),
        .ram_rgb   (i_ram_rgb),
        .ram_valid (i_ram_valid),
        .ready     (ready),
        .ram_read  (o_ram_read),
        .ram_addr  (o_ram_addr),
        .done      (done),
        .data      (port_data),
        .timeout   (tmo)
    );

    // Fetch request selection: a queued request goes before a new one.
    always_comb begin
        wrap       = i_active && (px == PX_W'(CELL_W - 1));
        chain_fire = (done || tmo) && !tgt_q && chain;
        wrap_fire  = wrap && (col <= LAST_FETCH_COL);
        new_req    = !i_line_start && (chain_fire || wrap_fire);
        new_col    = chain_fire ? 4'd1 : col + 4'd2;
        new_tgt    = 1'b1;
        req        = pend || new_req;
        req_col    = pend ? pend_col : new_col;
        req_tgt    = pend ? pend_tgt : new_tgt;
        accept     = req && ready && !i_line_start;
        req_addr   = {row, req_col};
        fill       = done ? port_data : ERR_COLOR;
    end

    // Raster position; frame_start is applied before line_start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            px         <= '0;
            col        <= '0;
            lic        <= '0;
            row        <= '0;
            first_line <= 1'b0;
        end else begin
            if (i_frame_start) begin
                row        <= '0;
                lic        <= '0;
                first_line <= 1'b1;
            end
            if (i_line_start) begin
                px  <= '0;
                col <= '0;
                if (i_frame_start || first_line) begin
                    first_line <= 1'b0;
                end else if (lic == LN_W'(CELL_H - 1)) begin
                    lic <= '0;
                    row <= row + 4'd1;
                end else begin
                    lic <= lic + LN_W'(1);
                end
            end else if (wrap) begin
                px  <= '0;
                col <= col + 4'd1;
            end else if (i_active) begin
                px <= px + PX_W'(1);
            end
        end
    end

    // Request queue; a line start drops everything and queues col0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend     <= 1'b0;
            pend_col <= '0;
            pend_tgt <= 1'b0;
            tgt_q    <= 1'b0;
            chain    <= 1'b0;
        end else if (i_line_start) begin
            pend     <= 1'b1;
            pend_col <= '0;
            pend_tgt <= 1'b0;
            chain    <= 1'b1;
        end else begin
            pend <= accept ? (pend && new_req) : (pend || new_req);
            if (new_req) begin
                pend_col <= new_col;
                pend_tgt <= new_tgt;
            end
            if (accept)
                tgt_q <= req_tgt;
            if (chain_fire)
                chain <= 1'b0;
        end
    end

    // Colour buffers: shift on cell wrap, then land fetch results.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cur   <= '0;
            nxt   <= '0;
            o_err <= 1'b0;
        end else begin
            if (wrap && !i_line_start)
                cur <= nxt;
            if (done || tmo) begin
                if (tgt_q)
                    nxt <= fill;
                else
                    cur <= fill;
            end
            if (tmo)
                o_err <= 1'b1;
            if (i_frame_start)
                o_err <= 1'b0;
        end
    end

    // Registered pixel output, blanked outside the active area.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rgb <= '0;
            o_de  <= 1'b0;
        end else begin
            o_rgb <= i_active ? cur : '0;
            o_de  <= i_active;
        end
    end

endmodule

// File: tb/tb_vga_ram_fetch.sv
// Directed bench for vga_ram_fetch with a latency-2 RAM model
// and a pixel scoreboard.
module tb_vga_ram_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fs = 1'b0, ls = 1'b0, act = 1'b0;
    logic [23:0] ram_rgb;
    logic        ram_valid;
    logic        o_ram_read, o_de, o_err;
    logic [7:0]  o_ram_addr;
    logic [23:0] o_rgb;

    logic        ram_en = 1'b1;
    logic        d1 = 1'b0, m_valid = 1'b0;
    logic [7:0]  a1 = 8'h0;
    logic [23:0] m_rgb = 24'h0;
    logic        inj_valid = 1'b0;
    logic [23:0] inj_rgb = 24'h0;

    int          errors = 0;
    int          checks = 0;
    logic [23:0] exp_q[$];
    logic [7:0]  logq[$];
    bit          rd_prev = 1'b0;
    int          low_cnt = 2;

    localparam logic [23:0] ERR = 24'hFF00FF;

    always #5 clk = ~clk;

    vga_ram_fetch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_start (fs),
        .i_line_start  (ls),
        .i_active      (act),
        .i_ram_rgb     (ram_rgb),
        .i_ram_valid   (ram_valid),
        .o_ram_read    (o_ram_read),
        .o_ram_addr    (o_ram_addr),
        .o_rgb         (o_rgb),
        .o_de          (o_de),
        .o_err         (o_err)
    );

    always @(posedge clk) begin
        d1      <= o_ram_read;
        a1      <= o_ram_addr;
        m_valid <= d1 & ram_en;
        m_rgb   <= {a1, a1, a1};
    end

    assign ram_valid = m_valid | inj_valid;
    assign ram_rgb   = inj_valid ? inj_rgb : m_rgb;

    function automatic logic [23:0] cell_rgb(logic [3:0] r, int p);
        logic [7:0] a;
        a = {r, 4'(p / 40)};
        return {a, a, a};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic de_exp;
        logic [23:0] e;
        de_exp = act & !rst;
        @(posedge clk);
        #1;
        chk("o_de", o_de, de_exp);
        if (de_exp) begin
            chk("sb_depth", exp_q.size(), 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
            chk("o_rgb", o_rgb, e);
        end else begin
            chk("o_rgb_blank", o_rgb, 0);
        end
        if (o_ram_read) begin
            chk("rd_width", rd_prev, 0);
            if (!rd_prev)
                chk("rd_gap", low_cnt >= 2, 1);
            logq.push_back(o_ram_addr);
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
        rd_prev = o_ram_read;
    endtask

    task automatic drv(bit f, bit l, bit a, logic [23:0] c);
        fs  = f;
        ls  = l;
        act = a;
        if (a)
            exp_q.push_back(c);
        tick();
    endtask

    task automatic line(bit f, logic [3:0] row, int npix,
                        bit errmode, bit c41);
        drv(f, 1'b1, 1'b0, 24'h0);
        repeat (24) drv(1'b0, 1'b0, 1'b0, 24'h0);
        for (int p = 0; p < npix; p++) begin
            drv(1'b0, 1'b0, 1'b1, errmode ? ERR : cell_rgb(row, p));
            if (c41 && p == 38)
                chk("rd_c40", o_ram_read, 0);
            if (c41 && p == 39) begin
                chk("rd_c41", o_ram_read, 1);
                chk("addr_c41", o_ram_addr, 8'h02);
            end
        end
        repeat (8) drv(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic chk_log(logic [7:0] base);
        logic [7:0] want;
        chk("log_len", logq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            want = base + 8'(i);
            chk("log_addr", (i < logq.size()) ? logq[i] : 8'hxx, want);
        end
    endtask

    initial begin
        repeat (3) drv(1'b0, 1'b0, 1'b0, 24'h0);
        chk("rst_rgb", o_rgb, 0);
        chk("rst_de", o_de, 0);
        chk("rst_err", o_err, 0);
        chk("rst_rd", o_ram_read, 0);
        chk("rst_addr", o_ram_addr, 0);
        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 24'h0);

        logq.delete();
        line(1'b1, 4'h0, 640, 1'b0, 1'b1);
        chk_log(8'h00);

        repeat (29) begin
            drv(1'b0, 1'b1, 1'b0, 24'h0);
            repeat (25) drv(1'b0, 1'b0, 1'b0, 24'h0);
        end
        logq.delete();
        line(1'b0, 4'h1, 640, 1'b0, 1'b0);
        chk_log(8'h10);

        ram_en = 1'b0;
        line(1'b1, 4'h0, 120, 1'b1, 1'b0);
        chk("err_set", o_err, 1);
        ram_en = 1'b1;
        repeat (12) drv(1'b0, 1'b0, 1'b0, 24'h0);
        chk("err_sticky", o_err, 1);
        drv(1'b1, 1'b0, 1'b0, 24'h0);
        chk("err_clear", o_err, 0);

        drv(1'b0, 1'b1, 1'b0, 24'h0);
        drv(1'b0, 1'b0, 1'b0, 24'h0);
        chk("stale_req", o_ram_read, 1);
        drv(1'b0, 1'b0, 1'b0, 24'h0);
        drv(1'b0, 1'b1, 1'b0, 24'h0);
        inj_valid = 1'b1;
        inj_rgb   = 24'hABCDEF;
        drv(1'b0, 1'b0, 1'b0, 24'h0);
        inj_valid = 1'b0;
        repeat (23) drv(1'b0, 1'b0, 1'b0, 24'h0);
        for (int p = 0; p < 41; p++)
            drv(1'b0, 1'b0, 1'b1, cell_rgb(4'h0, p));
        chk("pre_rst_rgb", o_rgb, 24'h010101);

        rst = 1'b1;
        act = 1'b0;
        #2;
        chk("arst_rgb", o_rgb, 0);
        chk("arst_de", o_de, 0);
        chk("arst_rd", o_ram_read, 0);
        chk("arst_addr", o_ram_addr, 0);
        chk("arst_err", o_err, 0);
        exp_q.delete();
        drv(1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b0;
        drv(1'b0, 1'b0, 1'b0, 24'h0);
        logq.delete();
        line(1'b1, 4'h0, 80, 1'b0, 1'b0);
        chk("post_rst_n", logq.size() >= 2, 1);
        chk("post_rst_a0", (logq.size() > 0) ? logq[0] : 8'hxx, 8'h00);
        chk("post_rst_a1", (logq.size() > 1) ? logq[1] : 8'hxx, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
